// File: rtl/wb_iterative_divider_if.sv
// Wishbone B4 pipelined request/response bundle between the ALU and the divider.
interface wb_iterative_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 i_wb4s_cyc;
  logic                 i_wb4s_stb;
  logic [1:0]           i_wb4s_tgc;
  logic [2*WIDTH-1:0]   i_wb4s_data;
  logic                 o_wb4s_stall;
  logic                 o_wb4s_ack;
  logic [WIDTH-1:0]     o_wb4s_data;

  // ALU side drives the request.
  modport master (
    output i_wb4s_cyc, i_wb4s_stb, i_wb4s_tgc, i_wb4s_data,
    input  o_wb4s_stall, o_wb4s_ack, o_wb4s_data
  );

  // Divider side answers it.
  modport slave (
    input  i_wb4s_cyc, i_wb4s_stb, i_wb4s_tgc, i_wb4s_data,
    output o_wb4s_stall, o_wb4s_ack, o_wb4s_data
  );
endinterface

// File: rtl/wb_iterative_divider.sv
// Iterative radix-2 restoring divider behind a Wishbone B4 pipelined responder.
// One operation in flight; quotient/remainder and signed/unsigned chosen by tag.
module wb_iterative_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  wb_iterative_divider_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [1:0]       tgc;
  logic             quoNeg;
  logic             remNeg;

  logic             accept;
  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] magDividend;
  logic [WIDTH-1:0] magDivisor;
  logic [WIDTH:0]   remShift;
  logic             noBorrow;
  logic [WIDTH-1:0] trialDiff;
  logic [WIDTH-1:0] result;

  // Request acceptance and next-state selection; cyc low aborts any operation.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_wb4s_cyc && bus.i_wb4s_stb) begin
          accept    = 1'b1;
          stateNext = PREP;
        end
      end
      PREP:    stateNext = bus.i_wb4s_cyc ? ITER : IDLE;
      ITER: begin
        if (!bus.i_wb4s_cyc) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = FIX;
        end
      end
      FIX:     stateNext = bus.i_wb4s_cyc ? ACK : IDLE;
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath helpers: operand magnitudes, one restoring step, final sign fix-up.
  always_comb begin
    dividendNeg = !tgc[0] && quo[WIDTH-1];
    divisorNeg  = !tgc[0] && div[WIDTH-1];
    magDividend = dividendNeg ? (~quo + WIDTH'(1)) : quo;
    magDivisor  = divisorNeg  ? (~div + WIDTH'(1)) : div;
    remShift    = {rem, quo[WIDTH-1]};
    noBorrow    = remShift >= {1'b0, div};
    // When no borrow the true difference is below the divisor, so the low bits suffice.
    trialDiff   = remShift[WIDTH-1:0] - div;
    if (tgc[1]) begin
      result = remNeg ? (~rem + WIDTH'(1)) : rem;
    end else begin
      result = quoNeg ? (~quo + WIDTH'(1)) : quo;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Operand latch, sign preparation and shift-subtract iterations.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      div    <= '0;
      tgc    <= '0;
      quoNeg <= 1'b0;
      remNeg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo <= bus.i_wb4s_data[WIDTH-1:0];
            div <= bus.i_wb4s_data[2*WIDTH-1:WIDTH];
            tgc <= bus.i_wb4s_tgc;
            rem <= '0;
          end
        end
        PREP: begin
          quo    <= magDividend;
          div    <= magDivisor;
          // A zero divisor yields all-ones quotient regardless of signs.
          quoNeg <= (dividendNeg ^ divisorNeg) && (div != '0);
          remNeg <= dividendNeg;
          rem    <= '0;
          cnt    <= CNT_W'(WIDTH - 1);
        end
        ITER: begin
          if (noBorrow) begin
            rem <= trialDiff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= remShift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered bus outputs; result only reloads on the FIX->ACK transition.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.o_wb4s_stall <= 1'b0;
      bus.o_wb4s_ack   <= 1'b0;
      bus.o_wb4s_data  <= '0;
    end else begin
      bus.o_wb4s_stall <= (stateNext != IDLE);
      bus.o_wb4s_ack   <= (state == FIX) && (stateNext == ACK);
      if ((state == FIX) && (stateNext == ACK)) begin
        bus.o_wb4s_data <= result;
      end
    end
  end

endmodule
